aes_mix_columns_pipe: RTL and testbench

Parametrised, pipelined AES MixColumns engine that replaces the per-byte constant-multiply lookup tables with computed GF(2^8) arithmetic. Each accepted beat carries NUM_COLS 32-bit state columns and a mode bit: forward (coefficients 02/03/01/01) or inverse (0E/0B/0D/09). It sits between ShiftRows and AddRoundKey in the round datapath. A valid/ready handshake gives a fixed two-cycle latency with full back-pressure support.

---
 rtl/aes_gf_pkg.sv | 45 ++++
 rtl/aes_mix_column_lane.sv | 21 ++
 rtl/aes_mix_columns_pipe.sv | 121 ++++++++++++
 tb/tb_aes_mix_columns_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and MixColumns coefficients shared by the pipelined MixColumns engine.
// Inverse support is selected by AES_MIXCOL_INV_EN.
package aes_gf_pkg;

   localparam logic [7:0] AES_POLY_LOW = 8'h1B;

   // Every MixColumns coefficient fits in a nibble: bit i selects the x(2^i) partial product.
   localparam logic [3:0] FWD_COEF0 = 4'h2;
   localparam logic [3:0] FWD_COEF1 = 4'h3;
   localparam logic [3:0] FWD_COEF2 = 4'h1;
   localparam logic [3:0] FWD_COEF3 = 4'h1;
   localparam logic [3:0] INV_COEF0 = 4'hE;
   localparam logic [3:0] INV_COEF1 = 4'hB;
   localparam logic [3:0] INV_COEF2 = 4'hD;
   localparam logic [3:0] INV_COEF3 = 4'h9;

   typedef logic [3:0][7:0] column_t;

   typedef struct packed {
      logic [7:0] x8;
      logic [7:0] x4;
      logic [7:0] x2;
      logic [7:0] x1;
   } pp_t;

   function automatic logic [7:0] gf_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LOW : 8'h00);
   endfunction

   function automatic logic [7:0] pp_mul(input pp_t p, input logic [3:0] coef);
      return ({8{coef[3]}} & p.x8) ^ ({8{coef[2]}} & p.x4) ^
             ({8{coef[1]}} & p.x2) ^ ({8{coef[0]}} & p.x1);
   endfunction

   // Coefficient applied to a_{r+k} when forming output row r.
   function automatic logic [3:0] mix_coef(input logic inv, input logic [1:0] k);
      case (k)
         2'd0:    return inv ? INV_COEF0 : FWD_COEF0;
         2'd1:    return inv ? INV_COEF1 : FWD_COEF1;
         2'd2:    return inv ? INV_COEF2 : FWD_COEF2;
         default: return inv ? INV_COEF3 : FWD_COEF3;
      endcase
   endfunction

endpackage

// File: rtl/aes_mix_column_lane.sv
// Combinational XOR combine of one column's partial products into four MixColumns output rows.
// Zero latency, no flow control; in forward-only builds (AES_MIXCOL_INV_EN undefined) inv is tied low.
module aes_mix_column_lane
   import aes_gf_pkg::*;
(
   input  logic           inv,
   input  pp_t  [3:0]     pp,
   output column_t        col
);

   // pp is indexed by row; row 0 lands in the top byte of the column.
   always_comb begin
      col = '0;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            col[2'(3 - r)] ^= pp_mul(pp[2'(r + k)], mix_coef(inv, 2'(k)));
         end
      end
   end

endmodule

// File: rtl/aes_mix_columns_pipe.sv
// Two-stage MixColumns / InvMixColumns engine with valid/ready back-pressure; beats emerge two cycles after acceptance.
// AES_MIXCOL_INV_EN builds the inverse path; without it Inv_Mode is ignored and only b, x2(b) are staged.
module aes_mix_columns_pipe
   import aes_gf_pkg::*;
#(
   parameter int NUM_COLS = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   input  logic [32*NUM_COLS-1:0]  In_Data,
   input  logic                    Inv_Mode,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic [32*NUM_COLS-1:0]  Out_Data
);

   localparam int NB = 4 * NUM_COLS;

   logic v1, v2;
   logic s1_ready, s2_ready;
   logic s1_load, s2_load;

   logic [NB-1:0][7:0] in_b, in_x2;
   logic [NB-1:0][7:0] s1_x1, s1_x2;
   logic               lane_inv;
   column_t [NUM_COLS-1:0] col_res;

   assign s2_ready = !v2 || Out_Ready;
   assign s1_ready = !v1 || s2_ready;
   assign In_Ready = s1_ready;
   assign s1_load  = In_Valid && s1_ready;
   assign s2_load  = v1 && s2_ready;

   assign in_b = In_Data;

`ifdef AES_MIXCOL_INV_EN
   logic [NB-1:0][7:0] in_x4, in_x8;
   logic [NB-1:0][7:0] s1_x4, s1_x8;
   logic               s1_inv;

   for (genvar i = 0; i < NB; i++) begin : g_pp
      assign in_x2[i] = gf_xtime(in_b[i]);
      assign in_x4[i] = gf_xtime(in_x2[i]);
      assign in_x8[i] = gf_xtime(in_x4[i]);
   end

   assign lane_inv = s1_inv;
`else
   logic unused_inv_mode;

   for (genvar i = 0; i < NB; i++) begin : g_pp
      assign in_x2[i] = gf_xtime(in_b[i]);
   end

   assign unused_inv_mode = Inv_Mode;
   assign lane_inv        = 1'b0;
`endif

   // Valid flags: load from upstream when ready, which also drains an idle stage.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         if (s1_ready) v1 <= In_Valid;
         if (s2_ready) v2 <= v1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_x1  <= '0;
         s1_x2  <= '0;
`ifdef AES_MIXCOL_INV_EN
         s1_x4  <= '0;
         s1_x8  <= '0;
         s1_inv <= 1'b0;
`endif
      end else if (s1_load) begin
         s1_x1  <= in_b;
         s1_x2  <= in_x2;
`ifdef AES_MIXCOL_INV_EN
         s1_x4  <= in_x4;
         s1_x8  <= in_x8;
         s1_inv <= Inv_Mode;
`endif
      end
   end

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      pp_t [3:0] pp;

      // Byte 4c+3 of the flat vector is row 0 of column c.
      for (genvar r = 0; r < 4; r++) begin : g_row
`ifdef AES_MIXCOL_INV_EN
         assign pp[r] = {s1_x8[4*c+3-r], s1_x4[4*c+3-r], s1_x2[4*c+3-r], s1_x1[4*c+3-r]};
`else
         assign pp[r] = {8'h00, 8'h00, s1_x2[4*c+3-r], s1_x1[4*c+3-r]};
`endif
      end

      aes_mix_column_lane u_lane (
         .inv (lane_inv),
         .pp  (pp),
         .col (col_res[c])
      );
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Out_Data <= '0;
      end else if (s2_load) begin
         Out_Data <= col_res;
      end
   end

   assign Out_Valid = v2;

endmodule

// File: tb/tb_aes_mix_columns_pipe.sv
// Directed-vector bench for aes_mix_columns_pipe (NUM_COLS=4); expectations follow AES_MIXCOL_INV_EN.
module tb_aes_mix_columns_pipe;

   localparam int NC = 4;
   localparam int NV = 10;

   logic            CLK;
   logic            RST;
   logic            In_Valid;
   logic            In_Ready;
   logic [32*NC-1:0] In_Data;
   logic            Inv_Mode;
   logic            Out_Valid;
   logic            Out_Ready;
   logic [32*NC-1:0] Out_Data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [127:0] din;
      logic         inv;
      logic [127:0] dout;
   } vec_t;

   vec_t vecs [NV];

   aes_mix_columns_pipe #(.NUM_COLS(NC)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .In_Data   (In_Data),
      .Inv_Mode  (Inv_Mode),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out_Data  (Out_Data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [127:0] rep(input logic [31:0] x);
      return {x, x, x, x};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   logic [127:0] held;

   initial begin
      vecs[0] = '{rep(32'hDB135345), 1'b0, rep(32'h8E4DA1BC)};
      vecs[1] = '{rep(32'hF20A225C), 1'b0, rep(32'h9FDC589D)};
      vecs[2] = '{rep(32'h01010101), 1'b0, rep(32'h01010101)};
      vecs[3] = '{rep(32'hC6C6C6C6), 1'b0, rep(32'hC6C6C6C6)};
      vecs[4] = '{rep(32'hD4D4D4D5), 1'b0, rep(32'hD5D5D7D6)};
      vecs[5] = '{rep(32'h2D26314C), 1'b0, rep(32'h4D7EBDF8)};
`ifdef AES_MIXCOL_INV_EN
      vecs[6] = '{rep(32'h8E4DA1BC), 1'b1, rep(32'hDB135345)};
      vecs[8] = '{rep(32'h9FDC589D), 1'b1, rep(32'hF20A225C)};
`else
      vecs[6] = '{rep(32'hDB135345), 1'b1, rep(32'h8E4DA1BC)};
      vecs[8] = '{rep(32'hF20A225C), 1'b1, rep(32'h9FDC589D)};
`endif
      vecs[7] = '{rep(32'h01010101), 1'b1, rep(32'h01010101)};
      vecs[9] = '{{32'hC6C6C6C6, 32'h01010101, 32'hF20A225C, 32'hDB135345}, 1'b0,
                  {32'hC6C6C6C6, 32'h01010101, 32'h9FDC589D, 32'h8E4DA1BC}};

      RST       = 1'b1;
      In_Valid  = 1'b0;
      In_Data   = '0;
      Inv_Mode  = 1'b0;
      Out_Ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check1("reset_in_ready", In_Ready, 1'b1);
      check1("reset_out_valid", Out_Valid, 1'b0);
      check("reset_out_data", Out_Data, '0);
      RST = 1'b0;

      // Streaming: modes alternate freely, one result per cycle, two cycles after drive.
      for (int k = 0; k < NV + 2; k++) begin
         if (k < NV) begin
            In_Valid = 1'b1;
            In_Data  = vecs[k].din;
            Inv_Mode = vecs[k].inv;
         end else begin
            In_Valid = 1'b0;
            In_Data  = rep(32'hFFFFFFFF);
            Inv_Mode = 1'b1;
         end
         @(negedge CLK);
         if (k < NV) check1("stream_in_ready", In_Ready, 1'b1);
         if (k >= 2) begin
            check1("stream_out_valid", Out_Valid, 1'b1);
            check($sformatf("stream_vec%0d", k - 2), Out_Data, vecs[k - 2].dout);
         end else begin
            check1("stream_fill_valid", Out_Valid, 1'b0);
         end
         next_cycle();
      end
      @(negedge CLK);
      check1("stream_drained", Out_Valid, 1'b0);
      next_cycle();

      // Back-pressure: Out_Ready low while beats keep coming.
      Out_Ready = 1'b0;
      In_Valid  = 1'b1;
      In_Data   = vecs[0].din;
      Inv_Mode  = vecs[0].inv;
      @(negedge CLK);
      check1("bp_accept_a", In_Ready, 1'b1);
      next_cycle();
      In_Data  = vecs[6].din;
      Inv_Mode = vecs[6].inv;
      @(negedge CLK);
      check1("bp_accept_b", In_Ready, 1'b1);
      check1("bp_not_yet_valid", Out_Valid, 1'b0);
      next_cycle();
      In_Data  = vecs[1].din;
      Inv_Mode = vecs[1].inv;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check1("bp_full_in_ready", In_Ready, 1'b0);
         check1("bp_hold_valid", Out_Valid, 1'b1);
         check("bp_hold_data", Out_Data, vecs[0].dout);
         next_cycle();
      end
      Out_Ready = 1'b1;
      @(negedge CLK);
      check1("bp_release_in_ready", In_Ready, 1'b1);
      check("bp_out_a", Out_Data, vecs[0].dout);
      next_cycle();
      In_Valid = 1'b0;
      @(negedge CLK);
      check1("bp_valid_b", Out_Valid, 1'b1);
      check("bp_out_b", Out_Data, vecs[6].dout);
      next_cycle();
      @(negedge CLK);
      check1("bp_valid_c", Out_Valid, 1'b1);
      check("bp_out_c", Out_Data, vecs[1].dout);
      next_cycle();
      @(negedge CLK);
      check1("bp_empty", Out_Valid, 1'b0);
      next_cycle();

      // Reset with both stages full, input still valid during reset.
      Out_Ready = 1'b0;
      In_Valid  = 1'b1;
      In_Data   = vecs[2].din;
      Inv_Mode  = vecs[2].inv;
      next_cycle();
      In_Data = vecs[3].din;
      next_cycle();
      check1("rst_pre_full", Out_Valid, 1'b1);
      held = Out_Data;
      check("rst_pre_data", held, vecs[2].dout);
      In_Data = vecs[1].din;
      RST = 1'b1;
      #1;
      check1("rst_out_valid", Out_Valid, 1'b0);
      check("rst_out_data", Out_Data, '0);
      check1("rst_in_ready", In_Ready, 1'b1);
      next_cycle();
      RST       = 1'b0;
      Out_Ready = 1'b1;
      In_Data   = vecs[5].din;
      Inv_Mode  = vecs[5].inv;
      @(negedge CLK);
      check1("rst_nothing_taken", Out_Valid, 1'b0);
      next_cycle();
      In_Valid = 1'b0;
      @(negedge CLK);
      check1("rst_latency_gap", Out_Valid, 1'b0);
      next_cycle();
      @(negedge CLK);
      check1("rst_first_valid", Out_Valid, 1'b1);
      check("rst_first_data", Out_Data, vecs[5].dout);
      next_cycle();
      @(negedge CLK);
      check1("rst_single_beat", Out_Valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
